div_11_reconstruct: RTL and testbench
=====================================

# div_11_reconstruct

Digit-serial reconstructor for the divide-by-11 datapath. It takes a quotient/remainder pair and rebuilds the dividend x = 11·q + r at 4 bits per cycle. It flags an illegal remainder (r > 10) and any result overflow beyond X_W bits. It sits on the result side of the constant-division units as the inverse operator, for self-check and round-trip verification.

## Interface

Parameters:
- X_W, 32: dividend/result width in bits; must be a multiple of 4. NIB = X_W/4 digit steps.

Ports:
- clk  input  1  clock. One clock domain; every register updates on its rising edge.
- rst  input  1  reset. Synchronous and active-high.
- in_valid  input  1  q/r pair presented.
- in_ready  output  1  block can accept a pair.
- q  input  X_W  quotient, unsigned.
- r  input  4  remainder, unsigned; legal range 0..10.
- out_valid  output  1  result held on outputs.
- out_ready  input  1  consumer accepts the result.
- x  output  X_W  low X_W bits of 11·q + r.
- ovf  output  1  11·q + r ≥ 2^X_W.
- err  output  1  r > 10 at accept time.

## Operation

- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: load the shift register qs ← q and carry ← r, zero-extended to 5 bits.
  - Latch err ← (r > 10). Set cnt ← 0 and go to RUN.
- RUN, one digit step per cycle:
  - t = 11·qs[3:0] + carry, 8-bit arithmetic; t ≤ 11·15 + 15 = 180.
  - x ← {t[3:0], x[X_W-1:4]}: the digit enters at the MSB end, so after NIB steps the LSB digit sits at x[3:0].
  - qs ← qs >> 4, carry ← t >> 4, cnt ← cnt + 1.
  - After step NIB-1: ovf ← (final carry ≠ 0) and go to DONE.
- DONE:
  - out_valid = 1. x, ovf and err stay stable.
  - On out_ready, go to IDLE.
- Arithmetic is exact modulo 2^X_W.
  - Overflow is judged only by the final carry.
  - An illegal r still produces the arithmetic result 11·q + r; err is informational only.
- in_valid is ignored outside IDLE. in_ready is low in RUN and DONE, so no input is dropped silently.
- out_ready is ignored outside DONE.

## Timing

- Reset, synchronous: on any edge with rst = 1, regardless of state:
  - state ← IDLE.
  - x, ovf, err, qs, carry and cnt ← 0.
  - out_valid = 0.
- in_ready = (state == IDLE) & ~rst, so it is low during reset cycles.
- Reset mid-RUN or mid-DONE:
  - The operation is abandoned and no out_valid pulse is produced.
  - in_ready is high on the first cycle after rst deasserts.
- Latency:
  - Accept edge at cycle 0.
  - RUN occupies cycles 1..NIB.
  - out_valid rises at cycle NIB+1, which is cycle 9 for X_W = 32.
- Handshake:
  - The result transfers on an edge with out_valid & out_ready.
  - in_ready is high the following cycle.
  - No same-cycle turnaround: minimum spacing between accepts is NIB+2 cycles.
- Backpressure: DONE holds indefinitely while out_ready = 0. Outputs must not change during that time.
- Outputs are registered; out_valid and in_ready decode directly from the state register.
- Simultaneous in_valid and rst: reset wins and nothing is accepted.

## Test plan

- q = 0, r = 0 -> x = 0, ovf = 0, err = 0, with out_valid at cycle 9 after the accept.
- q = 390451572 (0x1745D174), r = 3 -> x = 0xFFFFFFFF, ovf = 0, err = 0 (maximum legal dividend).
- q = 390451573, r = 0 -> 11·q = 4294967303 -> x = 7, ovf = 1, err = 0.
- q = 5, r = 11 -> x = 66, err = 1, ovf = 0. Then q = 5, r = 10 -> x = 65, err = 0.
- Backpressure: hold out_ready = 0 for 5 cycles after out_valid and pulse in_valid during RUN/DONE.
  - Required: x/ovf/err stable and no extra accept.
  - After out_ready, in_ready = 1 on the next cycle.
- Assert rst for 1 cycle at RUN step 4 of q = 123456, r = 7.
  - Required: out_valid stays 0 and all outputs read 0.
  - The next accepted pair, q = 123456, r = 7, yields x = 1358023.

Source files
------------

// File: rtl/div_11_reconstruct_if.sv
// ---------------------------------------------------------------------------
// div_11_reconstruct_if
// Handshake and data bundle for the divide-by-11 reconstructor.
//   in_valid / in_ready   : accept a quotient/remainder pair
//   q [X_W]               : quotient, unsigned
//   r [4]                 : remainder, legal range 0..10
//   out_valid / out_ready : hand the rebuilt dividend to the consumer
//   x [X_W]               : low X_W bits of 11*q + r
//   ovf                   : 11*q + r does not fit in X_W bits
//   err                   : r was greater than 10 when the pair was accepted
// The slave modport is the reconstructor's side of the bundle.
// The master modport is the producer/consumer side.
// ---------------------------------------------------------------------------
interface div_11_reconstruct_if #(
   parameter int X_W = 32
);
   logic           in_valid;
   logic           in_ready;
   logic [X_W-1:0] q;
   logic [3:0]     r;
   logic           out_valid;
   logic           out_ready;
   logic [X_W-1:0] x;
   logic           ovf;
   logic           err;

   modport slave (
      input  in_valid, q, r, out_ready,
      output in_ready, out_valid, x, ovf, err
   );

   modport master (
      output in_valid, q, r, out_ready,
      input  in_ready, out_valid, x, ovf, err
   );
endinterface

// File: rtl/div_11_reconstruct.sv
// ---------------------------------------------------------------------------
// div_11_reconstruct
// Rebuilds the dividend x = 11*q + r from a quotient/remainder pair.
// It processes one 4-bit digit of q per cycle, starting from the least
// significant digit. It flags an illegal remainder (err) and any result that
// does not fit in X_W bits (ovf).
//   clk : clock, every register updates on its rising edge
//   rst : synchronous, active-high reset
//   bus : div_11_reconstruct_if.slave carrying the in/out handshakes, q, r,
//         x, ovf and err
// Latency: for an accept edge at cycle 0, out_valid is high from cycle X_W/4+1.
// The result is held until out_ready.
// ---------------------------------------------------------------------------
module div_11_reconstruct #(
   parameter int X_W = 32
) (
   input logic                clk,
   input logic                rst,
   div_11_reconstruct_if.slave bus
);

   localparam int NIB   = X_W / 4;
   localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t           r_state;
   logic [X_W-1:0]   r_qs;
   logic [4:0]       r_carry;
   logic [CNT_W-1:0] r_cnt;
   logic [X_W-1:0]   r_x;
   logic             r_ovf;
   logic             r_err;
   logic [7:0]       w_t;

   // One digit step: 11*digit + carry peaks at 11*15 + 15 = 180, so 8 bits
   // always hold it exactly. The high nibble is the carry into the next digit.
   assign w_t = (8'd11 * {4'd0, r_qs[3:0]}) + {3'd0, r_carry};

   // Handshake flags decode straight from the state register.
   // in_ready is also masked by rst, so nothing is accepted while reset is high.
   assign bus.in_ready  = (r_state == IDLE) && !rst;
   assign bus.out_valid = (r_state == DONE);
   assign bus.x         = r_x;
   assign bus.ovf       = r_ovf;
   assign bus.err       = r_err;

   // Single-process FSM.
   // Each result digit is shifted in at the MSB end. After NIB steps the
   // least significant digit has reached x[3:0] and no separate
   // reassembly pass is needed.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_qs    <= '0;
         r_carry <= '0;
         r_cnt   <= '0;
         r_x     <= '0;
         r_ovf   <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.in_valid) begin
                  r_qs    <= bus.q;
                  r_carry <= {1'b0, bus.r};
                  r_err   <= (bus.r > 4'd10);
                  r_cnt   <= '0;
                  r_state <= RUN;
               end
            end
            RUN: begin
               r_x     <= {w_t[3:0], r_x[X_W-1:4]};
               r_qs    <= r_qs >> 4;
               r_carry <= {1'b0, w_t[7:4]};
               r_cnt   <= r_cnt + 1'b1;
               if (r_cnt == CNT_W'(NIB - 1)) begin
                  // Any carry left after the top digit is weight 2^X_W or more.
                  r_ovf   <= (w_t[7:4] != 4'd0);
                  r_state <= DONE;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  r_state <= IDLE;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div_11_reconstruct.sv
// ---------------------------------------------------------------------------
// tb_div_11_reconstruct
// Directed bench for div_11_reconstruct with X_W = 32.
// Each scenario task drives its own stimulus and checks the results against
// expected values worked out by hand.
// ---------------------------------------------------------------------------
module tb_div_11_reconstruct;

   localparam int X_W = 32;

   logic clk;
   logic rst;
   int   testCount;
   int   failCount;

   div_11_reconstruct_if #(.X_W(X_W)) bus ();

   div_11_reconstruct #(.X_W(X_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   // 10 ns clock period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Presents one pair and waits, with a bound, until out_valid is high.
   // The accept edge counts as cycle 1 of the latency.
   // out_ready is left low, so the result stays held for the caller.
   task automatic applyStimulus(input logic [X_W-1:0] qIn, input logic [3:0] rIn,
                                output logic [X_W-1:0] xOut, output logic ovfOut,
                                output logic errOut, output int lat);
      bus.q         = qIn;
      bus.r         = rIn;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b0;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      lat = 1;
      while (!bus.out_valid && lat < 50) begin
         @(posedge clk);
         #1;
         lat++;
      end
      xOut   = bus.x;
      ovfOut = bus.ovf;
      errOut = bus.err;
   endtask

   // Releases a held result with a single out_ready pulse.
   task automatic releaseResult();
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst          = 1'b1;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      bus.q        = '0;
      bus.r        = '0;
      repeat (2) @(posedge clk);
      #1;
      testCount++;
      if ({bus.out_valid, bus.in_ready, bus.ovf, bus.err} !== 4'b0000 || bus.x !== 32'd0) begin
         failCount++;
         $display("[TB] FAIL reset_state: got ov=%b ir=%b ovf=%b err=%b x=%h, want all zero",
                  bus.out_valid, bus.in_ready, bus.ovf, bus.err, bus.x);
      end
      rst = 1'b0;
      #1;
      testCount++;
      if (bus.in_ready !== 1'b1) begin
         failCount++;
         $display("[TB] FAIL reset_release_in_ready: got %b, want 1", bus.in_ready);
      end
   endtask

   task automatic test_zero();
      logic [X_W-1:0] x;
      logic ovf, err;
      int lat;
      applyStimulus(32'd0, 4'd0, x, ovf, err, lat);
      testCount++;
      if (lat !== 9) begin
         failCount++;
         $display("[TB] FAIL zero_latency: got %0d cycles, want 9", lat);
      end
      testCount++;
      if (x !== 32'd0 || ovf !== 1'b0 || err !== 1'b0) begin
         failCount++;
         $display("[TB] FAIL zero_result: got x=%h ovf=%b err=%b, want x=0 ovf=0 err=0", x, ovf, err);
      end
      releaseResult();
      testCount++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
         failCount++;
         $display("[TB] FAIL zero_release: got ir=%b ov=%b, want ir=1 ov=0", bus.in_ready, bus.out_valid);
      end
   endtask

   task automatic test_max_legal();
      logic [X_W-1:0] x;
      logic ovf, err;
      int lat;
      applyStimulus(32'h1745_D174, 4'd3, x, ovf, err, lat);
      testCount++;
      if (x !== 32'hFFFF_FFFF || ovf !== 1'b0 || err !== 1'b0 || lat !== 9) begin
         failCount++;
         $display("[TB] FAIL max_legal: got x=%h ovf=%b err=%b lat=%0d, want x=ffffffff ovf=0 err=0 lat=9",
                  x, ovf, err, lat);
      end
      releaseResult();
   endtask

   task automatic test_overflow();
      logic [X_W-1:0] x;
      logic ovf, err;
      int lat;
      applyStimulus(32'd390451573, 4'd0, x, ovf, err, lat);
      testCount++;
      if (x !== 32'd7 || ovf !== 1'b1 || err !== 1'b0) begin
         failCount++;
         $display("[TB] FAIL overflow: got x=%0d ovf=%b err=%b, want x=7 ovf=1 err=0", x, ovf, err);
      end
      releaseResult();
   endtask

   task automatic test_err();
      logic [X_W-1:0] x;
      logic ovf, err;
      int lat;
      applyStimulus(32'd5, 4'd11, x, ovf, err, lat);
      testCount++;
      if (x !== 32'd66 || ovf !== 1'b0 || err !== 1'b1) begin
         failCount++;
         $display("[TB] FAIL illegal_r: got x=%0d ovf=%b err=%b, want x=66 ovf=0 err=1", x, ovf, err);
      end
      releaseResult();
      applyStimulus(32'd5, 4'd10, x, ovf, err, lat);
      testCount++;
      if (x !== 32'd65 || ovf !== 1'b0 || err !== 1'b0) begin
         failCount++;
         $display("[TB] FAIL edge_r10: got x=%0d ovf=%b err=%b, want x=65 ovf=0 err=0", x, ovf, err);
      end
      releaseResult();
   endtask

   // 1000*11 + 4 = 11004.
   // in_valid stays high with a different pair throughout RUN and DONE.
   task automatic test_backpressure();
      int lat;
      bus.q         = 32'd1000;
      bus.r         = 4'd4;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b0;
      @(posedge clk);
      #1;
      bus.q = 32'd7;
      bus.r = 4'd1;
      lat = 1;
      while (!bus.out_valid && lat < 50) begin
         @(posedge clk);
         #1;
         lat++;
      end
      testCount++;
      if (bus.x !== 32'd11004 || bus.ovf !== 1'b0 || bus.err !== 1'b0 || lat !== 9) begin
         failCount++;
         $display("[TB] FAIL bp_result: got x=%0d ovf=%b err=%b lat=%0d, want x=11004 ovf=0 err=0 lat=9",
                  bus.x, bus.ovf, bus.err, lat);
      end
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         testCount++;
         if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.x !== 32'd11004 ||
             bus.ovf !== 1'b0 || bus.err !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL bp_hold_%0d: got ov=%b ir=%b x=%0d ovf=%b err=%b, want ov=1 ir=0 x=11004 ovf=0 err=0",
                     i, bus.out_valid, bus.in_ready, bus.x, bus.ovf, bus.err);
         end
      end
      bus.in_valid = 1'b0;
      releaseResult();
      testCount++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
         failCount++;
         $display("[TB] FAIL bp_release: got ir=%b ov=%b, want ir=1 ov=0", bus.in_ready, bus.out_valid);
      end
   endtask

   // Reset arrives on the edge of RUN step 4.
   // in_valid is held high on that same edge to show that reset wins.
   task automatic test_reset_mid_run();
      logic [X_W-1:0] x;
      logic ovf, err;
      int lat;
      logic sawValid;
      bus.q         = 32'd123456;
      bus.r         = 4'd7;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b0;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst          = 1'b1;
      bus.in_valid = 1'b1;
      #1;
      testCount++;
      if (bus.in_ready !== 1'b0) begin
         failCount++;
         $display("[TB] FAIL rst_in_ready_low: got %b, want 0", bus.in_ready);
      end
      @(posedge clk);
      #1;
      testCount++;
      if ({bus.out_valid, bus.ovf, bus.err} !== 3'b000 || bus.x !== 32'd0) begin
         failCount++;
         $display("[TB] FAIL rst_mid_run_outputs: got ov=%b x=%h ovf=%b err=%b, want all zero",
                  bus.out_valid, bus.x, bus.ovf, bus.err);
      end
      rst          = 1'b0;
      bus.in_valid = 1'b0;
      #1;
      testCount++;
      if (bus.in_ready !== 1'b1) begin
         failCount++;
         $display("[TB] FAIL rst_then_ready: got %b, want 1", bus.in_ready);
      end
      sawValid = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk);
         #1;
         if (bus.out_valid) sawValid = 1'b1;
      end
      testCount++;
      if (sawValid !== 1'b0) begin
         failCount++;
         $display("[TB] FAIL rst_no_out_valid: got out_valid pulse %b, want 0", sawValid);
      end
      applyStimulus(32'd123456, 4'd7, x, ovf, err, lat);
      testCount++;
      if (x !== 32'd1358023 || ovf !== 1'b0 || err !== 1'b0 || lat !== 9) begin
         failCount++;
         $display("[TB] FAIL rst_rerun: got x=%0d ovf=%b err=%b lat=%0d, want x=1358023 ovf=0 err=0 lat=9",
                  x, ovf, err, lat);
      end
      releaseResult();
   endtask

   // Runs every scenario in order, then prints the summary.
   initial begin
      testCount = 0;
      failCount = 0;
      test_reset();
      test_zero();
      test_max_legal();
      test_overflow();
      test_err();
      test_backpressure();
      test_reset_mid_run();
      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
